// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues word fetches over req/gnt/rvalid,
// buffers responses with their PCs and hands them to decode; redirects flush and re-steer.
module fetch_stage #(
   parameter int unsigned     XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = 32'h8000_0000,
   parameter int unsigned     FIFO_DEPTH = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [XLEN-1:0] jump_pc_i,
   input  logic            jump_pc_valid_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_rdata_i,
   output logic [XLEN-1:0] instr_o,
   output logic [XLEN-1:0] instr_pc_o,
   output logic            instr_valid_o,
   input  logic            instr_ready_i
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   // Stale responses owed by memory; bounded by memory's own in-flight capacity.
   localparam int unsigned DISC_W = 16;

   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0]  outstanding_q, outstanding_d;
   logic [DISC_W-1:0] discard_q, discard_d;

   logic [XLEN-1:0]   fifo_pc_q [FIFO_DEPTH];
   logic [31:0]       fifo_instr_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [XLEN-1:0]   jump_target;
   logic [CNT_W:0]    credit_used;
   logic              grant;
   logic              drop;
   logic              push;
   logic              pop;
   logic [1:0]        unused_jump_lsbs;

   assign unused_jump_lsbs = jump_pc_i[1:0];
   assign jump_target      = {jump_pc_i[XLEN-1:2], 2'b00};

   // Credit covers both buffered and non-stale in-flight fetches, so every
   // accepted response is guaranteed a free FIFO slot.
   assign credit_used = {1'b0, outstanding_q} + {1'b0, count_q};
   assign imem_req_o  = !rst_i && !jump_pc_valid_i && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
   assign imem_addr_o = pc_q;

   assign grant = imem_req_o && imem_gnt_i;
   assign drop  = imem_rvalid_i && (discard_q != '0);
   assign push  = imem_rvalid_i && (discard_q == '0) && !jump_pc_valid_i;
   assign pop   = instr_valid_o && instr_ready_i && !jump_pc_valid_i;

   always_comb begin
      pc_d          = pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      if (jump_pc_valid_i) begin
         pc_d          = jump_target;
         resp_pc_d     = jump_target;
         outstanding_d = '0;
         // Everything still in flight becomes stale; a response landing now is already paid.
         discard_d     = discard_q + DISC_W'(outstanding_q)
                         - DISC_W'(imem_rvalid_i && ((discard_q != '0) || (outstanding_q != '0)));
         rd_ptr_d      = '0;
         wr_ptr_d      = '0;
         count_d       = '0;
      end else begin
         if (grant) begin
            pc_d = pc_q + XLEN'(4);
         end
         if (drop) begin
            discard_d = discard_q - DISC_W'(1);
         end
         if (push) begin
            resp_pc_d = resp_pc_q + XLEN'(4);
            wr_ptr_d  = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(push);
         count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q          <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         pc_q          <= pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
         fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
      end
   end

   assign instr_valid_o = (count_q != '0);
   assign instr_o       = instr_valid_o ? XLEN'(fifo_instr_q[rd_ptr_q]) : '0;
   assign instr_pc_o    = instr_valid_o ? fifo_pc_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: random memory/decode/redirect traffic checked every cycle against an
// epoch-tagged queue model, plus directed scenarios pinned with literal expectations.
module tb_fetch_stage;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] RPC   = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] jump_pc_i = '0;
   logic        jump_pc_valid_i = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i = 1'b0;
   logic        imem_rvalid_i = 1'b0;
   logic [31:0] imem_rdata_i = '0;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_valid_o;
   logic        instr_ready_i = 1'b0;

   always #5 clk = ~clk;

   fetch_stage #(
      .XLEN      (XLEN),
      .RESET_PC  (RPC),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .jump_pc_i      (jump_pc_i),
      .jump_pc_valid_i(jump_pc_valid_i),
      .imem_req_o     (imem_req_o),
      .imem_addr_o    (imem_addr_o),
      .imem_gnt_i     (imem_gnt_i),
      .imem_rvalid_i  (imem_rvalid_i),
      .imem_rdata_i   (imem_rdata_i),
      .instr_o        (instr_o),
      .instr_pc_o     (instr_pc_o),
      .instr_valid_o  (instr_valid_o),
      .instr_ready_i  (instr_ready_i)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] exp_pc;
      int unsigned epoch;
      int unsigned due;
   } mreq_t;
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   mreq_t       mem_q[$];
   ent_t        m_q[$];
   logic [31:0] m_fetch_pc = RPC;
   int unsigned m_epoch = 0;
   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;

   int          k_gnt = 100, k_ready = 100, k_jump = 0, k_rv = 100, k_minlat = 1, k_maxlat = 1;
   bit          hold_rst = 1'b1;
   bit          f_jump = 1'b0;
   logic [31:0] f_jpc = '0;
   bit          k_coin = 1'b0;
   bit          coin_hit = 1'b0;

   logic        s_req, s_valid, s_gnt, s_rv, s_jump, s_ready, s_rst;
   logic [31:0] s_addr, s_instr, s_ipc, s_jpc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
   endfunction

   function automatic logic [31:0] rand_target();
      case ($urandom_range(3))
         0:       return $urandom;
         1:       return 32'hFFFF_FFF0 | 32'($urandom_range(15));
         2:       return 32'h0000_1000 + 32'($urandom_range(63));
         default: return RPC + 32'($urandom_range(255));
      endcase
   endfunction

   function automatic int inflight_cur();
      int n = 0;
      foreach (mem_q[i]) if (mem_q[i].epoch == m_epoch) n++;
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock: drive at negedge, compare against the model, then advance the model at posedge.
   task automatic step();
      mreq_t p;
      logic  exp_req;
      @(negedge clk);
      rst_i         = hold_rst;
      imem_gnt_i    = ($urandom_range(99) < k_gnt);
      instr_ready_i = ($urandom_range(99) < k_ready);
      if (!hold_rst && mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(99) < k_rv) begin
         imem_rvalid_i = 1'b1;
         imem_rdata_i  = mem_word(mem_q[0].addr);
      end else begin
         imem_rvalid_i = 1'b0;
         imem_rdata_i  = $urandom;
      end
      if (f_jump) begin
         jump_pc_valid_i = 1'b1;
         jump_pc_i       = f_jpc;
         f_jump          = 1'b0;
      end else if (k_coin && imem_rvalid_i && instr_ready_i && m_q.size() > 0) begin
         jump_pc_valid_i = 1'b1;
         jump_pc_i       = rand_target();
         k_coin          = 1'b0;
         coin_hit        = 1'b1;
      end else begin
         jump_pc_valid_i = ($urandom_range(99) < k_jump);
         jump_pc_i       = rand_target();
      end
      #1;
      s_req = imem_req_o;     s_addr  = imem_addr_o;   s_valid = instr_valid_o;
      s_instr = instr_o;      s_ipc   = instr_pc_o;    s_gnt   = imem_gnt_i;
      s_rv = imem_rvalid_i;   s_jump  = jump_pc_valid_i; s_jpc = jump_pc_i;
      s_ready = instr_ready_i; s_rst  = rst_i;

      exp_req = !s_rst && !s_jump && (inflight_cur() + m_q.size() < DEPTH);
      chk("req", 32'(s_req), 32'(exp_req));
      chk("addr", s_addr, m_fetch_pc);
      chk("valid", 32'(s_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
         chk("instr_pc", s_ipc, m_q[0].pc);
         chk("instr", s_instr, m_q[0].instr);
      end

      @(posedge clk);
      if (s_rst) begin
         mem_q.delete();
         m_q.delete();
         m_fetch_pc = RPC;
         m_epoch++;
      end else begin
         if (!s_jump && s_ready && m_q.size() > 0) void'(m_q.pop_front());
         if (s_rv) begin
            p = mem_q.pop_front();
            if (!s_jump && p.epoch == m_epoch) m_q.push_back('{p.exp_pc, mem_word(p.exp_pc)});
         end
         if (s_req && s_gnt) begin
            mem_q.push_back('{s_addr, m_fetch_pc, m_epoch,
                              cyc + $urandom_range(k_maxlat, k_minlat)});
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
         if (s_jump) begin
            m_q.delete();
            m_epoch++;
            m_fetch_pc = {s_jpc[31:2], 2'b00};
         end
      end
      cyc++;
   endtask

   task automatic wait_valid(input string name);
      for (int i = 0; i < 30; i++) begin
         step();
         if (s_valid) return;
      end
      chk(name, 32'(s_valid), 32'd1);
   endtask

   initial begin
      logic [31:0] pc_hold;
      repeat (2) @(posedge clk);

      // Reset values
      hold_rst = 1'b1;
      step();
      chk("rst_req", 32'(s_req), 32'd0);
      chk("rst_addr", s_addr, 32'h8000_0000);
      chk("rst_valid", 32'(s_valid), 32'd0);
      chk("rst_instr", s_instr, 32'd0);
      chk("rst_ipc", s_ipc, 32'd0);

      // Decode stalled: two grants fill credit, head holds on RESET_PC
      hold_rst = 1'b0;
      k_ready  = 0;
      step();
      chk("first_req", 32'(s_req), 32'd1);
      chk("first_addr", s_addr, 32'h8000_0000);
      step();
      chk("second_addr", s_addr, 32'h8000_0004);
      repeat (6) step();
      chk("stall_req", 32'(s_req), 32'd0);
      chk("stall_valid", 32'(s_valid), 32'd1);
      chk("stall_ipc", s_ipc, 32'h8000_0000);
      chk("stall_instr", s_instr, mem_word(32'h8000_0000));
      k_ready = 100;
      repeat (20) step();

      // Grant withheld: request and address stable
      k_gnt = 0;
      repeat (6) step();
      pc_hold = m_fetch_pc;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("nognt_req", 32'(s_req), 32'd1);
         chk("nognt_addr", s_addr, pc_hold);
      end

      // Redirect with two outstanding fetches
      k_gnt = 100; k_minlat = 3; k_maxlat = 3;
      for (int i = 0; i < 20 && inflight_cur() < 2; i++) step();
      chk("two_outstanding", 32'(inflight_cur()), 32'd2);
      f_jump = 1'b1; f_jpc = 32'h0000_1002;
      step();
      k_minlat = 1; k_maxlat = 1;
      step();
      chk("redir_req", 32'(s_req), 32'd1);
      chk("redir_addr", s_addr, 32'h0000_1000);
      wait_valid("redir_timeout");
      chk("redir_ipc", s_ipc, 32'h0000_1000);

      // Wrap of the address space
      f_jump = 1'b1; f_jpc = 32'hFFFF_FFFC;
      step();
      step();
      chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
      step();
      chk("wrap_addr1", s_addr, 32'h0000_0000);
      wait_valid("wrap_timeout0");
      chk("wrap_ipc0", s_ipc, 32'hFFFF_FFFC);
      wait_valid("wrap_timeout1");
      chk("wrap_ipc1", s_ipc, 32'h0000_0000);

      // Redirect coinciding with a response and a pop
      coin_hit = 1'b0; k_coin = 1'b1;
      for (int i = 0; i < 50 && !coin_hit; i++) step();
      chk("coin_seen", 32'(coin_hit), 32'd1);
      k_coin = 1'b0;
      step();
      chk("coin_flush", 32'(s_valid), 32'd0);

      // Reset pulse mid-stream
      repeat (7) step();
      hold_rst = 1'b1;
      step();
      chk("midrst_req", 32'(s_req), 32'd0);
      hold_rst = 1'b0;
      step();
      chk("midrst_valid", 32'(s_valid), 32'd0);
      chk("midrst_ipc", s_ipc, 32'd0);
      chk("midrst_instr", s_instr, 32'd0);
      chk("midrst_addr", s_addr, RPC);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         if (i % 200 == 0) begin
            k_gnt    = $urandom_range(100, 30);
            k_ready  = $urandom_range(100, 20);
            k_rv     = $urandom_range(100, 50);
            k_jump   = $urandom_range(10);
            k_minlat = 1;
            k_maxlat = $urandom_range(4, 1);
         end
         hold_rst = ($urandom_range(499) == 0);
         step();
      end
      hold_rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
